// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst arbiter sharing one async-FIFO read port among NREQ requesters
module fifo_rd_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 8,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic            rclk_i,
    input  logic            rrst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            fifo_empty_i,
    input  logic            fifo_almost_empty_i,
    output logic            ren_o,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic [NREQ-1:0] rvalid_o,
    output logic            burst_done_o,
    output logic            busy_o
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] nxt_ptr;
    logic           found;
    logic [CW-1:0]  cnt;
    logic           burst_end;
    logic           unused_almost_empty;

    // Empty is checked combinationally on every pop, so almost-empty carries no extra information here
    assign unused_almost_empty = fifo_almost_empty_i;
    assign ren_o     = (state == BURST) & ~rrst_i & req_i[gnt_id_o] & ~fifo_empty_i;
    assign busy_o    = (state != IDLE);
    assign burst_end = (ren_o & (cnt == CW'(BURST_LEN - 1))) | ~req_i[gnt_id_o] | fifo_empty_i;
    assign nxt_ptr   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    // Round-robin search from rr_ptr; scanning downward lets the nearest requester overwrite farther ones
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(rr_ptr) + i) % NREQ);
            if (req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // FSM, grant, word counter and read-valid pipeline
    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            gnt_o        <= '0;
            gnt_id_o     <= '0;
            rvalid_o     <= '0;
            burst_done_o <= 1'b0;
        end else begin
            rvalid_o     <= ren_o ? gnt_o : '0;
            burst_done_o <= 1'b0;
            if (state == IDLE) begin
                if (found & ~fifo_empty_i) begin
                    state    <= BURST;
                    gnt_o    <= NREQ'(1) << win;
                    gnt_id_o <= win;
                    cnt      <= '0;
                    rr_ptr   <= nxt_ptr;
                end
            end else if (state == BURST) begin
                cnt <= cnt + CW'(ren_o);
                if (burst_end) begin
                    state        <= GAP;
                    gnt_o        <= '0;
                    gnt_id_o     <= '0;
                    burst_done_o <= 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed checks of burst arbitration against a word-counting FIFO model
module tb_fifo_rd_arbiter;
    logic       rclk_i = 1'b0;
    logic       rrst_i;
    logic [3:0] req_i;
    logic       fifo_empty_i;
    logic       fifo_almost_empty_i;
    logic       ren_o;
    logic [3:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic [3:0] rvalid_o;
    logic       burst_done_o;
    logic       busy_o;

    int         words;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       s_ren, s_done, s_busy, s_empty;
    logic [3:0] s_gnt, s_rv;
    logic [1:0] s_id;

    assign fifo_empty_i        = (words == 0);
    assign fifo_almost_empty_i = (words <= 1);

    always #5 rclk_i = ~rclk_i;

    fifo_rd_arbiter #(.NREQ(4), .BURST_LEN(8)) dut (
        .rclk_i(rclk_i),
        .rrst_i(rrst_i),
        .req_i(req_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_almost_empty_i(fifo_almost_empty_i),
        .ren_o(ren_o),
        .gnt_o(gnt_o),
        .gnt_id_o(gnt_id_o),
        .rvalid_o(rvalid_o),
        .burst_done_o(burst_done_o),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then let the FIFO model consume a popped word
    task automatic cyc();
        @(negedge rclk_i);
        s_ren   = ren_o;
        s_gnt   = gnt_o;
        s_id    = gnt_id_o;
        s_rv    = rvalid_o;
        s_done  = burst_done_o;
        s_busy  = busy_o;
        s_empty = fifo_empty_i;
        chk("pop_on_empty", {31'b0, s_ren & s_empty}, 0);
        @(posedge rclk_i);
        #1;
        if (s_ren && words > 0) words--;
    endtask

    task automatic idle();
        cyc();
        chk("idle_gnt", s_gnt, 0);
        chk("idle_ren", s_ren, 0);
        chk("idle_busy", s_busy, 0);
        chk("idle_done", s_done, 0);
        chk("idle_rv", s_rv, 0);
    endtask

    // n pops expected; a short burst gets one extra non-popping BURST cycle before GAP
    task automatic burst(input logic [3:0] g, input logic [1:0] id, input int n, input bit drop);
        for (int k = 0; k < n; k++) begin
            cyc();
            chk("burst_gnt", s_gnt, g);
            chk("burst_id", s_id, id);
            chk("burst_ren", s_ren, 1);
            chk("burst_rv", s_rv, (k == 0) ? 4'b0 : g);
            chk("burst_busy", s_busy, 1);
        end
        if (drop) req_i = req_i & ~g;
        if (n < 8) begin
            cyc();
            chk("tail_gnt", s_gnt, g);
            chk("tail_ren", s_ren, 0);
            chk("tail_rv", s_rv, g);
            chk("tail_done", s_done, 0);
        end
        cyc();
        chk("gap_gnt", s_gnt, 0);
        chk("gap_ren", s_ren, 0);
        chk("gap_done", s_done, 1);
        chk("gap_rv", s_rv, (n < 8) ? 4'b0 : g);
        chk("gap_busy", s_busy, 1);
    endtask

    initial begin
        rrst_i = 1'b1;
        req_i  = 4'b0;
        words  = 0;
        cyc();
        cyc();
        chk("rst_gnt", s_gnt, 0);
        chk("rst_id", s_id, 0);
        chk("rst_rv", s_rv, 0);
        chk("rst_done", s_done, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_ren", s_ren, 0);
        rrst_i = 1'b0;

        // two requesters, 20 words: 0 then 2, eight pops each
        req_i = 4'b0101;
        words = 20;
        idle();
        burst(4'b0001, 2'd0, 8, 1'b0);
        idle();
        burst(4'b0100, 2'd2, 8, 1'b0);
        chk("words_after_two", words, 4);

        // only three words for requester 3: burst ends on empty
        req_i = 4'b1000;
        words = 3;
        idle();
        burst(4'b1000, 2'd3, 3, 1'b0);
        chk("words_drained", words, 0);

        // owner 0 drops after two pops, requester 1 follows
        req_i = 4'b0011;
        words = 10;
        idle();
        burst(4'b0001, 2'd0, 2, 1'b1);
        idle();
        burst(4'b0010, 2'd1, 8, 1'b0);

        // reset during what would be the 4th pop of requester 2
        req_i = 4'b1111;
        words = 100;
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("pre_rst_gnt", s_gnt, 4'b0100);
            chk("pre_rst_ren", s_ren, 1);
        end
        rrst_i = 1'b1;
        cyc();
        chk("rst_cycle_ren", s_ren, 0);
        rrst_i = 1'b0;
        idle();

        // all requesting, FIFO never empty: order 0,1,2,3,0
        burst(4'b0001, 2'd0, 8, 1'b0);
        idle();
        burst(4'b0010, 2'd1, 8, 1'b0);
        idle();
        burst(4'b0100, 2'd2, 8, 1'b0);
        idle();
        burst(4'b1000, 2'd3, 8, 1'b0);
        idle();
        burst(4'b0001, 2'd0, 8, 1'b0);
        chk("words_after_rr", words, 100 - 3 - 40);

        // requests against a permanently empty FIFO
        words = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("empty_gnt", s_gnt, 0);
            chk("empty_ren", s_ren, 0);
            chk("empty_busy", s_busy, 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
